// File: rtl/exe_pkg.sv
// Shared encodings for the multi-cycle execute stage: ALU commands,
// branch types, memory-control bit positions and the stage FSM states.
package exe_pkg;

  // ALU command encodings
  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_MUL = 4'b0011;
  localparam logic [3:0] CMD_AND = 4'b0100;
  localparam logic [3:0] CMD_OR  = 4'b0101;
  localparam logic [3:0] CMD_NOR = 4'b0110;
  localparam logic [3:0] CMD_XOR = 4'b0111;
  localparam logic [3:0] CMD_SLL = 4'b1000;
  localparam logic [3:0] CMD_SRA = 4'b1001;
  localparam logic [3:0] CMD_SRL = 4'b1010;
  localparam logic [3:0] CMD_SLT = 4'b1011;

  // Branch type encodings
  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEZ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;
  localparam logic [1:0] BR_JMP  = 2'b11;

  // Bit positions inside the 2-bit memory control field
  localparam int MEM_RD_BIT = 0;
  localparam int MEM_WR_BIT = 1;

  // Stage FSM
  typedef enum logic {
    IDLE     = 1'b0,
    MUL_BUSY = 1'b1
  } exe_state_t;

endpackage

// File: rtl/exe_mul_iter.sv
// Iterative shift-add multiplier. Each cycle it consumes XLEN/MUL_CYCLES
// multiplier bits. The product of the last iteration is presented
// combinationally together with the done pulse, so a consumer can register
// it on the MUL_CYCLES-th edge after start.
module exe_mul_iter #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CHUNK = XLEN / MUL_CYCLES;
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  logic [XLEN-1:0]  mcand_reg;
  logic [XLEN-1:0]  mplier_reg;
  logic [XLEN-1:0]  acc_reg;
  logic [CNT_W-1:0] count_reg;
  logic             active_reg;

  logic [XLEN-1:0]  pp [CHUNK];
  logic [XLEN-1:0]  acc_next;

  // One partial product per multiplier bit handled this iteration
  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_pp
      assign pp[gi] = mplier_reg[gi] ? (mcand_reg << gi) : '0;
    end
  endgenerate

  // Accumulate this iteration's partial products (wraps modulo 2^XLEN)
  always_comb begin
    acc_next = acc_reg;
    for (int j = 0; j < CHUNK; j++) begin
      acc_next = acc_next + pp[j];
    end
  end

  assign done    = active_reg & (count_reg == CNT_W'(MUL_CYCLES - 1));
  assign product = acc_next;

  // Iteration state: load on start, shift each cycle, drop on abort or finish
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      count_reg  <= '0;
      active_reg <= 1'b0;
    end else if (abort) begin
      acc_reg    <= '0;
      count_reg  <= '0;
      active_reg <= 1'b0;
    end else if (start) begin
      mcand_reg  <= a;
      mplier_reg <= b;
      acc_reg    <= '0;
      count_reg  <= '0;
      active_reg <= 1'b1;
    end else if (active_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << CHUNK;
      mplier_reg <= mplier_reg >> CHUNK;
      count_reg  <= count_reg + CNT_W'(1);
      if (done) begin
        active_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/exe_stage_mc.sv
// Execute stage with valid/ready handshake on both sides, synchronous flush,
// combinational ALU and branch resolution, an iterative multiplier and the
// EXE/MEM pipeline register.
module exe_stage_mc
  import exe_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DEST_W     = 5,
  parameter int MUL_CYCLES = 4,
  parameter int ADDR_SHIFT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic              wb_en_in,
  input  logic [1:0]        mem_sig_in,
  input  logic [DEST_W-1:0] dest_in,
  input  logic [3:0]        exe_cmd,
  input  logic [XLEN-1:0]   val1,
  input  logic [XLEN-1:0]   val2,
  input  logic [XLEN-1:0]   reg2,
  input  logic [XLEN-1:0]   pc,
  input  logic [1:0]        br_type,
  output logic [XLEN-1:0]   br_addr,
  output logic              br_taken,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              wb_en_out,
  output logic [1:0]        mem_sig_out,
  output logic [DEST_W-1:0] dest_out,
  output logic [XLEN-1:0]   pc_out,
  output logic [XLEN-1:0]   alu_result_out,
  output logic [XLEN-1:0]   reg2_out,
  output logic              busy
);

  localparam int SH_W = $clog2(XLEN);

  exe_state_t        state_reg;
  logic              busy_reg;
  logic              out_valid_reg;
  logic              wb_en_reg;
  logic [1:0]        mem_sig_reg;
  logic [DEST_W-1:0] dest_reg;
  logic [XLEN-1:0]   pc_reg;
  logic [XLEN-1:0]   alu_reg;
  logic [XLEN-1:0]   reg2_reg;

  // Sideband captured while the multiplier runs
  logic              wb_en_hold_reg;
  logic [1:0]        mem_sig_hold_reg;
  logic [DEST_W-1:0] dest_hold_reg;
  logic [XLEN-1:0]   pc_hold_reg;
  logic [XLEN-1:0]   reg2_hold_reg;

  logic [XLEN-1:0]   alu_next;
  logic [SH_W-1:0]   shamt;
  logic              cond;
  logic              accept;
  logic              is_mul;
  logic              mul_done;
  logic [XLEN-1:0]   mul_product;

  assign shamt  = val2[SH_W-1:0];
  assign is_mul = (exe_cmd == CMD_MUL);

  // in_ready already excludes flush, so accept cannot fire in a flush cycle
  assign in_ready = rst & (state_reg == IDLE) & (~out_valid_reg | out_ready) & ~flush;
  assign accept   = in_valid & in_ready;

  // Single-cycle ALU; MUL and unknown codes yield 0 here
  always_comb begin
    alu_next = '0;
    case (exe_cmd)
      CMD_ADD: alu_next = val1 + val2;
      CMD_SUB: alu_next = val1 - val2;
      CMD_AND: alu_next = val1 & val2;
      CMD_OR:  alu_next = val1 | val2;
      CMD_NOR: alu_next = ~(val1 | val2);
      CMD_XOR: alu_next = val1 ^ val2;
      CMD_SLL: alu_next = val1 << shamt;
      CMD_SRA: alu_next = $signed(val1) >>> shamt;
      CMD_SRL: alu_next = val1 >> shamt;
      CMD_SLT: alu_next[0] = ($signed(val1) < $signed(val2));
      default: alu_next = '0;
    endcase
  end

  // Branch condition per branch type
  always_comb begin
    cond = 1'b0;
    case (br_type)
      BR_BEZ:  cond = (val1 == '0);
      BR_BNE:  cond = (val1 != reg2);
      BR_JMP:  cond = 1'b1;
      default: cond = 1'b0;
    endcase
  end

  assign br_addr  = pc + (val2 << ADDR_SHIFT);
  assign br_taken = accept & cond;

  exe_mul_iter #(
    .XLEN       (XLEN),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept & is_mul),
    .abort   (flush),
    .a       (val1),
    .b       (val2),
    .done    (mul_done),
    .product (mul_product)
  );

  // Stage FSM and EXE/MEM register: accept, multiply hand-off, flush and drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      busy_reg         <= 1'b0;
      out_valid_reg    <= 1'b0;
      wb_en_reg        <= 1'b0;
      mem_sig_reg      <= '0;
      dest_reg         <= '0;
      pc_reg           <= '0;
      alu_reg          <= '0;
      reg2_reg         <= '0;
      wb_en_hold_reg   <= 1'b0;
      mem_sig_hold_reg <= '0;
      dest_hold_reg    <= '0;
      pc_hold_reg      <= '0;
      reg2_hold_reg    <= '0;
    end else if (flush) begin
      state_reg     <= IDLE;
      busy_reg      <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept && is_mul) begin
            state_reg        <= MUL_BUSY;
            busy_reg         <= 1'b1;
            out_valid_reg    <= 1'b0;
            wb_en_hold_reg   <= wb_en_in;
            mem_sig_hold_reg <= mem_sig_in;
            dest_hold_reg    <= dest_in;
            pc_hold_reg      <= pc;
            reg2_hold_reg    <= reg2;
          end else if (accept) begin
            out_valid_reg <= 1'b1;
            wb_en_reg     <= wb_en_in;
            mem_sig_reg   <= mem_sig_in;
            dest_reg      <= dest_in;
            pc_reg        <= pc;
            alu_reg       <= alu_next;
            reg2_reg      <= reg2;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        MUL_BUSY: begin
          if (mul_done) begin
            state_reg     <= IDLE;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
            wb_en_reg     <= wb_en_hold_reg;
            mem_sig_reg   <= mem_sig_hold_reg;
            dest_reg      <= dest_hold_reg;
            pc_reg        <= pc_hold_reg;
            alu_reg       <= mul_product;
            reg2_reg      <= reg2_hold_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy           = busy_reg;
  assign out_valid      = out_valid_reg;
  assign wb_en_out      = wb_en_reg;
  assign mem_sig_out    = mem_sig_reg;
  assign dest_out       = dest_reg;
  assign pc_out         = pc_reg;
  assign alu_result_out = alu_reg;
  assign reg2_out       = reg2_reg;

endmodule

// File: tb/tb_exe_stage_mc.sv
// Directed bench for exe_stage_mc: 32-bit/4-cycle instance for the main
// sequence, plus a 16-bit/1-cycle instance for the multiplier corner.
module tb_exe_stage_mc;
  import exe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;

  // 32-bit instance
  logic        in_valid = 0, flush = 0, wb_en_in = 0, out_ready = 1;
  logic [1:0]  mem_sig_in = 0, br_type = 0;
  logic [4:0]  dest_in = 0;
  logic [3:0]  exe_cmd = 0;
  logic [31:0] val1 = 0, val2 = 0, reg2 = 0, pc = 0;
  logic        in_ready, br_taken, out_valid, wb_en_out, busy;
  logic [1:0]  mem_sig_out;
  logic [4:0]  dest_out;
  logic [31:0] br_addr, pc_out, alu_result_out, reg2_out;

  // 16-bit, single-iteration instance
  logic        in_valid_b = 0, flush_b = 0, out_ready_b = 1;
  logic [3:0]  exe_cmd_b = 0;
  logic [15:0] val1_b = 0, val2_b = 0, reg2_b = 0, pc_b = 0;
  logic        in_ready_b, br_taken_b, out_valid_b, wb_en_out_b, busy_b;
  logic [1:0]  mem_sig_out_b;
  logic [4:0]  dest_out_b;
  logic [15:0] br_addr_b, pc_out_b, alu_result_out_b, reg2_out_b;

  int checks = 0;
  int errors = 0;

  exe_stage_mc dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .wb_en_in(wb_en_in), .mem_sig_in(mem_sig_in), .dest_in(dest_in), .exe_cmd(exe_cmd),
    .val1(val1), .val2(val2), .reg2(reg2), .pc(pc), .br_type(br_type),
    .br_addr(br_addr), .br_taken(br_taken), .out_valid(out_valid), .out_ready(out_ready),
    .wb_en_out(wb_en_out), .mem_sig_out(mem_sig_out), .dest_out(dest_out), .pc_out(pc_out),
    .alu_result_out(alu_result_out), .reg2_out(reg2_out), .busy(busy)
  );

  exe_stage_mc #(.XLEN(16), .DEST_W(5), .MUL_CYCLES(1), .ADDR_SHIFT(2)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .flush(flush_b),
    .wb_en_in(1'b1), .mem_sig_in(2'b00), .dest_in(5'd1), .exe_cmd(exe_cmd_b),
    .val1(val1_b), .val2(val2_b), .reg2(reg2_b), .pc(pc_b), .br_type(BR_NONE),
    .br_addr(br_addr_b), .br_taken(br_taken_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .wb_en_out(wb_en_out_b), .mem_sig_out(mem_sig_out_b), .dest_out(dest_out_b), .pc_out(pc_out_b),
    .alu_result_out(alu_result_out_b), .reg2_out(reg2_out_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ALU table run after reset release: cmd, val1, val2, expected
  logic [3:0]  t_cmd [8] = '{CMD_SRA, CMD_SLT, CMD_SLT, 4'b1111, CMD_SRL, CMD_SLL, CMD_NOR, CMD_XOR};
  logic [31:0] t_v1  [8] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h5, 32'h8000_0000,
                             32'h1, 32'h0F0F_0F0F, 32'hFF00_FF00};
  logic [31:0] t_v2  [8] = '{32'h4, 32'h1, 32'hFFFF_FFFF, 32'h5, 32'h4, 32'h24, 32'h00FF_00FF,
                             32'h0FF0_0FF0};
  logic [31:0] t_exp [8] = '{32'hF800_0000, 32'h1, 32'h0, 32'h0, 32'h0800_0000, 32'h10,
                             32'hF000_F000, 32'hF0F0_F0F0};

  initial begin
    // Reset state
    #1 rst = 1'b0;
    #2;
    chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_in_ready", {31'b0, in_ready}, 32'h0);
    chk("reset_alu", alu_result_out, 32'h0);
    @(posedge clk);
    #1 rst = 1'b1;

    // ADD with sideband pass-through
    in_valid = 1; exe_cmd = CMD_ADD; val1 = 5; val2 = 7; dest_in = 5'd3;
    pc = 32'h100; reg2 = 32'h55; wb_en_in = 1; mem_sig_in = 2'b01; br_type = BR_NONE;
    #1;
    chk("add_in_ready", {31'b0, in_ready}, 32'h1);
    chk("add_br_taken_none", {31'b0, br_taken}, 32'h0);
    tick();
    chk("add_result", alu_result_out, 32'd12);
    chk("add_out_valid", {31'b0, out_valid}, 32'h1);
    chk("add_dest", {27'b0, dest_out}, 32'd3);
    chk("add_pc", pc_out, 32'h100);
    chk("add_reg2", reg2_out, 32'h55);
    chk("add_wb_en", {31'b0, wb_en_out}, 32'h1);
    chk("add_mem_sig", {30'b0, mem_sig_out}, 32'h1);

    // SUB wraps
    exe_cmd = CMD_SUB; val1 = 3; val2 = 5;
    tick();
    chk("sub_result", alu_result_out, 32'hFFFF_FFFE);

    // MUL, four iterations
    exe_cmd = CMD_MUL; val1 = 32'h0001_0003; val2 = 32'h10; dest_in = 5'd7; pc = 32'h200; reg2 = 32'h77;
    #1;
    chk("mul_in_ready_before", {31'b0, in_ready}, 32'h1);
    tick();
    in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mul_busy_%0d", i), {31'b0, busy}, 32'h1);
      chk($sformatf("mul_in_ready_%0d", i), {31'b0, in_ready}, 32'h0);
      chk($sformatf("mul_out_valid_%0d", i), {31'b0, out_valid}, 32'h0);
      tick();
    end
    chk("mul_result", alu_result_out, 32'h0010_0030);
    chk("mul_out_valid", {31'b0, out_valid}, 32'h1);
    chk("mul_busy_done", {31'b0, busy}, 32'h0);
    chk("mul_dest", {27'b0, dest_out}, 32'd7);
    chk("mul_pc", pc_out, 32'h200);
    chk("mul_reg2", reg2_out, 32'h77);

    // Stall: hold 0xAB while out_ready is low
    in_valid = 1; exe_cmd = CMD_ADD; val1 = 32'hA0; val2 = 32'h0B; dest_in = 5'd4;
    tick();
    chk("stall_load", alu_result_out, 32'hAB);
    out_ready = 0; val1 = 1; val2 = 1; dest_in = 5'd9;
    #1;
    chk("stall_in_ready", {31'b0, in_ready}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_hold_%0d", i), alu_result_out, 32'hAB);
      chk($sformatf("stall_valid_%0d", i), {31'b0, out_valid}, 32'h1);
      chk($sformatf("stall_dest_%0d", i), {27'b0, dest_out}, 32'd4);
      chk($sformatf("stall_ready_%0d", i), {31'b0, in_ready}, 32'h0);
    end
    out_ready = 1;
    #1;
    chk("release_in_ready", {31'b0, in_ready}, 32'h1);
    tick();
    chk("release_next_result", alu_result_out, 32'd2);
    chk("release_next_dest", {27'b0, dest_out}, 32'd9);

    // Branches (combinational, all within one cycle)
    exe_cmd = CMD_ADD; br_type = BR_BEZ; val1 = 0; val2 = 3; pc = 32'h1000; reg2 = 0;
    #1;
    chk("bez_taken", {31'b0, br_taken}, 32'h1);
    chk("bez_addr", br_addr, 32'h100C);
    br_type = BR_BNE; val1 = 9; reg2 = 9;
    #1 chk("bne_equal", {31'b0, br_taken}, 32'h0);
    reg2 = 8;
    #1 chk("bne_differ", {31'b0, br_taken}, 32'h1);
    br_type = BR_JMP;
    #1 chk("jmp_taken", {31'b0, br_taken}, 32'h1);
    br_type = BR_NONE;
    #1 chk("none_taken", {31'b0, br_taken}, 32'h0);
    br_type = BR_JMP; in_valid = 0;
    #1 chk("jmp_no_valid", {31'b0, br_taken}, 32'h0);
    br_type = BR_NONE;
    tick();
    chk("drain_out_valid", {31'b0, out_valid}, 32'h0);

    // Flush on the second cycle of a multiply
    in_valid = 1; exe_cmd = CMD_MUL; val1 = 6; val2 = 7;
    tick();
    in_valid = 0;
    chk("flush_mul_busy", {31'b0, busy}, 32'h1);
    tick();
    flush = 1;
    #1 chk("flush_in_ready", {31'b0, in_ready}, 32'h0);
    tick();
    chk("flush_busy", {31'b0, busy}, 32'h0);
    chk("flush_out_valid", {31'b0, out_valid}, 32'h0);
    flush = 0;
    #1 chk("flush_in_ready_after", {31'b0, in_ready}, 32'h1);
    repeat (5) tick();
    chk("flush_discarded", {31'b0, out_valid}, 32'h0);
    chk("flush_discarded_busy", {31'b0, busy}, 32'h0);
    // Flush together with an incoming instruction
    in_valid = 1; exe_cmd = CMD_ADD; val1 = 1; val2 = 1; br_type = BR_JMP; flush = 1;
    #1;
    chk("flush_in_br_taken", {31'b0, br_taken}, 32'h0);
    chk("flush_in_in_ready", {31'b0, in_ready}, 32'h0);
    tick();
    chk("flush_in_no_accept", {31'b0, out_valid}, 32'h0);
    flush = 0; in_valid = 0; br_type = BR_NONE;

    // Asynchronous reset mid-multiply
    in_valid = 1; exe_cmd = CMD_MUL; val1 = 2; val2 = 3;
    tick();
    in_valid = 0;
    tick();
    chk("areset_pre_busy", {31'b0, busy}, 32'h1);
    #2 rst = 0;
    #1;
    chk("areset_busy", {31'b0, busy}, 32'h0);
    chk("areset_out_valid", {31'b0, out_valid}, 32'h0);
    chk("areset_in_ready", {31'b0, in_ready}, 32'h0);
    chk("areset_alu", alu_result_out, 32'h0);
    chk("areset_dest", {27'b0, dest_out}, 32'h0);
    chk("areset_pc", pc_out, 32'h0);
    chk("areset_wb_en", {31'b0, wb_en_out}, 32'h0);
    @(posedge clk);
    #1 rst = 1;

    // ALU table after reset release
    in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      exe_cmd = t_cmd[i]; val1 = t_v1[i]; val2 = t_v2[i];
      tick();
      chk($sformatf("alu_cmd%0h_%0d", t_cmd[i], i), alu_result_out, t_exp[i]);
      chk($sformatf("alu_valid_%0d", i), {31'b0, out_valid}, 32'h1);
    end
    in_valid = 0;
    tick();

    // 16-bit single-iteration multiplier
    in_valid_b = 1; exe_cmd_b = CMD_MUL; val1_b = 16'h0103; val2_b = 16'h0010;
    #1 chk("b_in_ready", {31'b0, in_ready_b}, 32'h1);
    tick();
    in_valid_b = 0;
    chk("b_busy", {31'b0, busy_b}, 32'h1);
    chk("b_out_valid_busy", {31'b0, out_valid_b}, 32'h0);
    tick();
    chk("b_busy_done", {31'b0, busy_b}, 32'h0);
    chk("b_out_valid", {31'b0, out_valid_b}, 32'h1);
    chk("b_mul_result", {16'b0, alu_result_out_b}, 32'h1030);
    in_valid_b = 1; val1_b = 16'hFFFF; val2_b = 16'hFFFF;
    tick();
    in_valid_b = 0;
    tick();
    chk("b_mul_wrap", {16'b0, alu_result_out_b}, 32'h0001);
    in_valid_b = 1; val1_b = 16'h1234; val2_b = 16'h0100;
    tick();
    in_valid_b = 0;
    tick();
    chk("b_mul_trunc", {16'b0, alu_result_out_b}, 32'h3400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
